// File: rtl/score_event_arbiter.sv
// score_event_arbiter: round-robin award arbiter feeding two saturating player scores.
// Optional SCORE_EXTRA_LIFE_EN adds a once-per-game extra-life pulse per player.
module score_event_arbiter #(
  parameter int PELLET_PTS     = 10,
  parameter int POWER_PTS      = 50,
  parameter int GHOST_BASE_PTS = 200,
  parameter int SCORE_MAX      = 999999,
  parameter int EXTRA_LIFE_PTS = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [11:0] fruit_pts,
  input  logic        active_player,
  input  logic        combo_clr,
  input  logic        score_clr,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [19:0] score1,
  output logic [19:0] score2,
  output logic [1:0]  extra_life
);
  typedef enum logic {IDLE, ADD} state_t;
  state_t state, state_nxt;
  logic [1:0] rr_ptr, src, combo, gnt_src;
  logic gnt_any, player;
  logic [11:0] value, gnt_val;
  logic [19:0] cur, sum_sat;
  logic [20:0] sum;
  always_comb begin
    gnt_any = 1'b0;
    gnt_src = rr_ptr;
    for (int i = 4; i >= 1; i--)
      if (req[2'(rr_ptr + 2'(i))]) begin
        gnt_any = 1'b1;
        gnt_src = 2'(rr_ptr + 2'(i));
      end
    gnt_val = gnt_src == 2'd3 ? fruit_pts :
              gnt_src == 2'd2 ? 12'(GHOST_BASE_PTS) << (combo_clr ? 2'd0 : combo) :
              gnt_src == 2'd1 ? 12'(POWER_PTS) : 12'(PELLET_PTS);
    state_nxt = (state == IDLE && gnt_any) ? ADD : IDLE;
    ack = state == ADD ? 4'(4'b0001 << src) : 4'b0000;
    busy = state == ADD;
    cur = player ? score2 : score1;
    sum = {1'b0, cur} + 21'(value);
    sum_sat = sum > 21'(SCORE_MAX) ? 20'(SCORE_MAX) : sum[19:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_ptr <= 2'd3;
      src <= 2'd0;
      combo <= 2'd0;
      player <= 1'b0;
      value <= 12'd0;
      score1 <= 20'd0;
      score2 <= 20'd0;
    end else begin
      if (combo_clr) combo <= 2'd0;
      else if (state == ADD && src == 2'd2 && combo != 2'd3) combo <= combo + 2'd1;
      if (state == IDLE && gnt_any) begin
        src <= gnt_src;
        rr_ptr <= gnt_src;
        player <= active_player;
        value <= gnt_val;
      end
      if (score_clr) begin
        score1 <= 20'd0;
        score2 <= 20'd0;
      end else if (state == ADD) begin
        if (player) score2 <= sum_sat;
        else score1 <= sum_sat;
      end
    end
`ifdef SCORE_EXTRA_LIFE_EN
  logic [1:0] life_flag;
  logic cross;
  assign cross = state == ADD && !score_clr && !life_flag[player] &&
                 cur < 20'(EXTRA_LIFE_PTS) && sum_sat >= 20'(EXTRA_LIFE_PTS);
  // Pulse is registered so it appears together with the updated score.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      life_flag <= 2'b00;
      extra_life <= 2'b00;
    end else begin
      extra_life <= 2'b00;
      if (score_clr) life_flag <= 2'b00;
      else if (cross) begin
        life_flag[player] <= 1'b1;
        extra_life[player] <= 1'b1;
      end
    end
`else
  assign extra_life = 2'b00;
`endif
endmodule

// File: tb/tb_score_event_arbiter.sv
// tb_score_event_arbiter: directed checks of arbitration order, ghost combo, saturation,
// score clear and extra-life behaviour of score_event_arbiter.
module tb_score_event_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req = 4'b0;
  logic [11:0] fruit_pts = 12'd0;
  logic active_player = 1'b0, combo_clr = 1'b0, score_clr = 1'b0;
  logic [3:0] ack;
  logic busy;
  logic [19:0] score1, score2;
  logic [1:0] extra_life;
  int n_chk = 0, n_fail = 0;

  score_event_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .fruit_pts(fruit_pts),
    .active_player(active_player), .combo_clr(combo_clr), .score_clr(score_clr),
    .ack(ack), .busy(busy), .score1(score1), .score2(score2), .extra_life(extra_life)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise a request, wait (bounded) for its ack, then drop req after the ADD edge.
  task automatic award(input logic [3:0] r, input logic p, input logic [11:0] fp,
                       input logic clr, input logic [3:0] exp_ack);
    int k;
    req = r;
    active_player = p;
    fruit_pts = fp;
    combo_clr = clr;
    k = 0;
    do begin
      tick;
      combo_clr = 1'b0;
      k++;
    end while (ack == 4'b0 && k < 4);
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("busy", 32'(busy), 32'd1);
    chk("latency", 32'(k), 32'd1);
    tick;
    req = 4'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s1", 32'(score1), 32'd0);
    chk("rst_s2", 32'(score2), 32'd0);
    chk("rst_xl", 32'(extra_life), 32'd0);
    reset = 1'b0;
    // single pellet for player 1
    award(4'b0001, 1'b0, 12'd0, 1'b0, 4'b0001);
    chk("t1_s1", 32'(score1), 32'd10);
    chk("t1_s2", 32'(score2), 32'd0);
    chk("t1_ack_off", 32'(ack), 32'd0);
    // async reset during ADD: ack vanishes, arbiter pointer restarts
    req = 4'b0001;
    tick;
    chk("rstadd_ack_on", 32'(ack), 32'b0001);
    #2 reset = 1'b1;
    #1;
    chk("rstadd_ack", 32'(ack), 32'd0);
    chk("rstadd_busy", 32'(busy), 32'd0);
    chk("rstadd_s1", 32'(score1), 32'd0);
    reset = 1'b0;
    req = 4'b0;
    // round robin with all requests pending, fruit=300
    award(4'b1111, 1'b0, 12'd300, 1'b0, 4'b0001);
    chk("rr_s1_a", 32'(score1), 32'd10);
    award(4'b1111, 1'b0, 12'd300, 1'b0, 4'b0010);
    chk("rr_s1_b", 32'(score1), 32'd60);
    award(4'b1111, 1'b0, 12'd300, 1'b0, 4'b0100);
    chk("rr_s1_c", 32'(score1), 32'd260);
    award(4'b1111, 1'b0, 12'd300, 1'b0, 4'b1000);
    chk("rr_s1_d", 32'(score1), 32'd560);
    award(4'b1111, 1'b0, 12'd300, 1'b0, 4'b0001);
    chk("rr_s1_e", 32'(score1), 32'd570);
    // ghost combo for player 2 after restarting the combo
    combo_clr = 1'b1;
    tick;
    combo_clr = 1'b0;
    award(4'b0100, 1'b1, 12'd0, 1'b0, 4'b0100);
    chk("gh1", 32'(score2), 32'd200);
    award(4'b0100, 1'b1, 12'd0, 1'b0, 4'b0100);
    chk("gh2", 32'(score2), 32'd600);
    award(4'b0100, 1'b1, 12'd0, 1'b0, 4'b0100);
    chk("gh3", 32'(score2), 32'd1400);
    award(4'b0100, 1'b1, 12'd0, 1'b0, 4'b0100);
    chk("gh4", 32'(score2), 32'd3000);
    award(4'b0100, 1'b1, 12'd0, 1'b0, 4'b0100);
    chk("gh5_cap", 32'(score2), 32'd4600);
    award(4'b0100, 1'b1, 12'd0, 1'b1, 4'b0100);
    chk("gh_clr_grant", 32'(score2), 32'd4800);
    award(4'b0100, 1'b1, 12'd0, 1'b0, 4'b0100);
    chk("gh_after_clr", 32'(score2), 32'd5200);
    chk("gh_s1", 32'(score1), 32'd570);
    // climb player 1 to 999990 with fruit awards
    for (int i = 0; i < 244; i++) award(4'b1000, 1'b0, 12'd4095, 1'b0, 4'b1000);
    award(4'b1000, 1'b0, 12'd240, 1'b0, 4'b1000);
    chk("climb_s1", 32'(score1), 32'd999990);
    // saturation; player/fruit changes after grant must not matter
    req = 4'b1000;
    active_player = 1'b0;
    fruit_pts = 12'd100;
    tick;
    chk("sat_ack", 32'(ack), 32'b1000);
    active_player = 1'b1;
    fruit_pts = 12'd4095;
    tick;
    req = 4'b0;
    chk("sat_s1", 32'(score1), 32'd999999);
    chk("sat_s2", 32'(score2), 32'd5200);
    award(4'b0001, 1'b0, 12'd0, 1'b0, 4'b0001);
    chk("sat_hold", 32'(score1), 32'd999999);
    // score_clr during ADD discards the award but still acks
    req = 4'b0001;
    active_player = 1'b0;
    tick;
    score_clr = 1'b1;
    #1;
    chk("clr_add_ack", 32'(ack), 32'b0001);
    tick;
    score_clr = 1'b0;
    req = 4'b0;
    chk("clr_add_s1", 32'(score1), 32'd0);
    chk("clr_add_s2", 32'(score2), 32'd0);
    // score_clr in IDLE with a pending request: both proceed
    req = 4'b0010;
    score_clr = 1'b1;
    tick;
    score_clr = 1'b0;
    chk("clr_idle_ack", 32'(ack), 32'b0010);
    tick;
    req = 4'b0;
    chk("clr_idle_s1", 32'(score1), 32'd50);
    // extra life for player 2
    award(4'b1000, 1'b1, 12'd4095, 1'b0, 4'b1000);
    award(4'b1000, 1'b1, 12'd4095, 1'b0, 4'b1000);
    award(4'b1000, 1'b1, 12'd1800, 1'b0, 4'b1000);
    chk("xl_pre", 32'(score2), 32'd9990);
    chk("xl_pre_pulse", 32'(extra_life), 32'd0);
    award(4'b0001, 1'b1, 12'd0, 1'b0, 4'b0001);
    chk("xl_s2", 32'(score2), 32'd10000);
`ifdef SCORE_EXTRA_LIFE_EN
    chk("xl_pulse", 32'(extra_life), 32'b10);
`else
    chk("xl_pulse", 32'(extra_life), 32'b00);
`endif
    tick;
    chk("xl_pulse_end", 32'(extra_life), 32'd0);
    award(4'b0001, 1'b1, 12'd0, 1'b0, 4'b0001);
    chk("xl_again_s2", 32'(score2), 32'd10010);
    chk("xl_again", 32'(extra_life), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
